// File: rtl/raster_fetch_sched_if.sv
// raster_fetch_sched_if
//
// Bundles every handshake and bus signal of the raster stamp fetch scheduler.
//   req_*    : warp fetch requests (valid/ready, wid, tmask, uuid)
//   stamp_*  : raster unit stamp stream (valid/ready, data, lane mask, done)
//   write_*  : CSR stamp store write port (enable, uuid, wid, pid, tmask, data)
//   rsp_*    : completion response (valid/ready, wid, tmask, uuid)
//
// Modports:
//   master : the environment side (drives requests, stamps and rsp_ready)
//   slave  : the scheduler side (raster_fetch_sched)
//
// Parameters must match those of the raster_fetch_sched instance it connects to.
interface raster_fetch_sched_if #(
   parameter int NUM_LANES   = 1,
   parameter int NUM_THREADS = 4,
   parameter int NUM_WARPS   = 4,
   parameter int UUID_WIDTH  = 8,
   parameter int DATA_W      = 16
);
   localparam int NUM_BATCHES = NUM_THREADS / NUM_LANES;
   localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int PID_WIDTH   = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

   // fetch request
   logic                          req_valid;
   logic                          req_ready;
   logic [NW_WIDTH-1:0]           req_wid;
   logic [NUM_THREADS-1:0]        req_tmask;
   logic [UUID_WIDTH-1:0]         req_uuid;

   // raster stamp stream
   logic                          stamp_valid;
   logic                          stamp_ready;
   logic [NUM_LANES*DATA_W-1:0]   stamp_data;
   logic [NUM_LANES-1:0]          stamp_mask;
   logic                          stamp_done;

   // CSR stamp store write port
   logic                          write_enable;
   logic [UUID_WIDTH-1:0]         write_uuid;
   logic [NW_WIDTH-1:0]           write_wid;
   logic [PID_WIDTH-1:0]          write_pid;
   logic [NUM_LANES-1:0]          write_tmask;
   logic [NUM_LANES*DATA_W-1:0]   write_data;

   // completion response
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [NW_WIDTH-1:0]           rsp_wid;
   logic [NUM_THREADS-1:0]        rsp_tmask;
   logic [UUID_WIDTH-1:0]         rsp_uuid;

   modport master (
      output req_valid, req_wid, req_tmask, req_uuid,
      input  req_ready,
      output stamp_valid, stamp_data, stamp_mask, stamp_done,
      input  stamp_ready,
      input  write_enable, write_uuid, write_wid, write_pid, write_tmask, write_data,
      input  rsp_valid, rsp_wid, rsp_tmask, rsp_uuid,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_wid, req_tmask, req_uuid,
      output req_ready,
      input  stamp_valid, stamp_data, stamp_mask, stamp_done,
      output stamp_ready,
      output write_enable, write_uuid, write_wid, write_pid, write_tmask, write_data,
      output rsp_valid, rsp_wid, rsp_tmask, rsp_uuid,
      input  rsp_ready
   );
endinterface

// File: rtl/raster_fetch_sched.sv
// raster_fetch_sched
//
// Per-core scheduler for raster stamp fetches. Warps post a fetch request
// (thread mask + trace tag); pending warps are served round-robin. For the
// selected warp the stamp stream is consumed one PID batch per beat, batches
// with an empty thread slice are skipped, and each beat becomes one registered
// write into the per-thread CSR stamp store. When the fetch ends (last batch
// or stamp_done) a response returns the mask of threads that received stamps.
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous, active-low reset
//   bus      : raster_fetch_sched_if.slave (req_*, stamp_*, write_*, rsp_*)
//
// Optional feature (macro RASTER_FETCH_PERF_EN):
//   perf_stamps : 32-bit count of lanes written into the stamp store
//   perf_stalls : 32-bit count of FETCH cycles with stamp_valid low
//   Both cleared by reset and wrap at 2^32. Without the macro they do not exist.
module raster_fetch_sched #(
   parameter int NUM_LANES   = 1,
   parameter int NUM_THREADS = 4,
   parameter int NUM_WARPS   = 4,
   parameter int UUID_WIDTH  = 8,
   parameter int DATA_W      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   raster_fetch_sched_if.slave bus
`ifdef RASTER_FETCH_PERF_EN
   ,
   output logic [31:0]         perf_stamps,
   output logic [31:0]         perf_stalls
`endif
);
   localparam int NUM_BATCHES = NUM_THREADS / NUM_LANES;
   localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int PID_WIDTH   = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_RESP
   } state_t;

   // Lowest batch index >= start whose thread slice is nonzero.
   // Result is {found, index}.
   function automatic logic [PID_WIDTH:0] next_batch(
      input logic [NUM_THREADS-1:0] tm,
      input int                     start
   );
      logic [PID_WIDTH:0]   res;
      logic [NUM_LANES-1:0] slice;
      res = '0;
      // Walking downwards leaves the lowest qualifying batch in res.
      for (int b = NUM_BATCHES - 1; b >= 0; b--) begin
         slice = NUM_LANES'(tm >> (b * NUM_LANES));
         if (b >= start && (|slice)) begin
            res = {1'b1, PID_WIDTH'(b)};
         end
      end
      return res;
   endfunction

   function automatic logic [NW_WIDTH-1:0] wrap_inc(input logic [NW_WIDTH-1:0] w);
      if (int'(w) == NUM_WARPS - 1) begin
         return '0;
      end
      return w + NW_WIDTH'(1);
   endfunction

   // control state
   state_t                       state;
   logic [NUM_WARPS-1:0]         pending;
   logic [NW_WIDTH-1:0]          rr_ptr;
   logic                         stamp_ready_q;
   logic                         rsp_valid_q;

   // per-warp request storage (data only, qualified by pending)
   logic [NUM_THREADS-1:0]       tmask_q [NUM_WARPS];
   logic [UUID_WIDTH-1:0]        uuid_q  [NUM_WARPS];

   // active fetch context
   logic [NW_WIDTH-1:0]          cur_wid;
   logic [NUM_THREADS-1:0]       cur_tmask;
   logic [UUID_WIDTH-1:0]        cur_uuid;
   logic [PID_WIDTH-1:0]         pid;
   logic [NUM_THREADS-1:0]       acc_mask;

   // registered write port
   logic                         wr_en_p1;
   logic [UUID_WIDTH-1:0]        wr_uuid_p1;
   logic [NW_WIDTH-1:0]          wr_wid_p1;
   logic [PID_WIDTH-1:0]         wr_pid_p1;
   logic [NUM_LANES-1:0]         wr_tmask_p1;
   logic [NUM_LANES*DATA_W-1:0]  wr_data_p1;

   // combinational helpers
   logic                         req_fire;
   logic                         stamp_fire;
   logic                         rsp_fire;
   logic                         sel_found;
   logic [NW_WIDTH-1:0]          sel_wid;
   logic [NW_WIDTH-1:0]          cand;
   logic [NUM_THREADS-1:0]       sel_tmask;
   logic [PID_WIDTH:0]           sel_first;
   logic [PID_WIDTH:0]           nxt;
   logic [NUM_LANES-1:0]         cur_slice;
   logic [NUM_LANES-1:0]         wmask;
   logic [NUM_THREADS-1:0]       acc_next;

   assign bus.req_ready = !pending[bus.req_wid];
   assign req_fire      = bus.req_valid && !pending[bus.req_wid];
   // stamp_ready_q is high exactly while in FETCH
   assign stamp_fire    = bus.stamp_valid && stamp_ready_q;
   assign rsp_fire      = rsp_valid_q && bus.rsp_ready;

   // Round-robin pick: first pending warp at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_wid   = '0;
      cand      = '0;
      idx       = 0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx  = (int'(rr_ptr) + i) % NUM_WARPS;
         cand = NW_WIDTH'(idx);
         if (!sel_found && pending[cand]) begin
            sel_found = 1'b1;
            sel_wid   = cand;
         end
      end
   end

   always_comb begin
      sel_tmask = tmask_q[sel_wid];
      sel_first = next_batch(sel_tmask, 0);
      nxt       = next_batch(cur_tmask, int'(pid) + 1);
      cur_slice = NUM_LANES'(cur_tmask >> (int'(pid) * NUM_LANES));
      wmask     = cur_slice & bus.stamp_mask;
      acc_next  = acc_mask | (NUM_THREADS'(wmask) << (int'(pid) * NUM_LANES));
   end

   // Request payload capture; pending gates every use, so no reset is needed.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         tmask_q[bus.req_wid] <= bus.req_tmask;
         uuid_q[bus.req_wid]  <= bus.req_uuid;
      end
   end

   // ---- stage p0 -> p1: scheduler FSM and registered write/response outputs ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         pending       <= '0;
         rr_ptr        <= '0;
         stamp_ready_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         cur_wid       <= '0;
         cur_tmask     <= '0;
         cur_uuid      <= '0;
         pid           <= '0;
         acc_mask      <= '0;
         wr_en_p1      <= 1'b0;
         wr_uuid_p1    <= '0;
         wr_wid_p1     <= '0;
         wr_pid_p1     <= '0;
         wr_tmask_p1   <= '0;
         wr_data_p1    <= '0;
      end else begin
         // write strobe is a single-cycle pulse
         wr_en_p1 <= 1'b0;

         // Cannot collide with the clear below: cur_wid is pending, so its
         // request port is not ready.
         if (req_fire) begin
            pending[bus.req_wid] <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  cur_wid   <= sel_wid;
                  cur_tmask <= sel_tmask;
                  cur_uuid  <= uuid_q[sel_wid];
                  acc_mask  <= '0;
                  pid       <= sel_first[PID_WIDTH-1:0];
                  if (sel_first[PID_WIDTH]) begin
                     state         <= S_FETCH;
                     stamp_ready_q <= 1'b1;
                  end else begin
                     // empty thread mask: answer without touching the stream
                     state       <= S_RESP;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end

            S_FETCH: begin
               if (stamp_fire) begin
                  wr_en_p1    <= |wmask;
                  wr_tmask_p1 <= wmask;
                  wr_pid_p1   <= pid;
                  wr_wid_p1   <= cur_wid;
                  wr_uuid_p1  <= cur_uuid;
                  wr_data_p1  <= bus.stamp_data;
                  acc_mask    <= acc_next;
                  if (bus.stamp_done || !nxt[PID_WIDTH]) begin
                     // response rises together with the final write strobe
                     state         <= S_RESP;
                     stamp_ready_q <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                  end else begin
                     pid <= nxt[PID_WIDTH-1:0];
                  end
               end
            end

            S_RESP: begin
               if (rsp_fire) begin
                  pending[cur_wid] <= 1'b0;
                  rr_ptr           <= wrap_inc(cur_wid);
                  rsp_valid_q      <= 1'b0;
                  state            <= S_IDLE;
               end
            end

            default: begin
               state         <= S_IDLE;
               stamp_ready_q <= 1'b0;
               rsp_valid_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stamp_ready  = stamp_ready_q;
   assign bus.write_enable = wr_en_p1;
   assign bus.write_uuid   = wr_uuid_p1;
   assign bus.write_wid    = wr_wid_p1;
   assign bus.write_pid    = wr_pid_p1;
   assign bus.write_tmask  = wr_tmask_p1;
   assign bus.write_data   = wr_data_p1;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_wid      = cur_wid;
   assign bus.rsp_tmask    = acc_mask;
   assign bus.rsp_uuid     = cur_uuid;

`ifdef RASTER_FETCH_PERF_EN
   function automatic logic [31:0] popcount(input logic [NUM_LANES-1:0] m);
      logic [31:0]          c;
      logic [NUM_LANES-1:0] t;
      c = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         t = m >> i;
         c = c + {31'd0, t[0]};
      end
      return c;
   endfunction

   // ---- perf counters ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_stamps <= '0;
         perf_stalls <= '0;
      end else begin
         if (stamp_fire) begin
            perf_stamps <= perf_stamps + popcount(wmask);
         end
         if (state == S_FETCH && !bus.stamp_valid) begin
            perf_stalls <= perf_stalls + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_raster_fetch_sched.sv
`timescale 1ns/1ps
module tb_raster_fetch_sched;
   localparam int NUM_LANES   = 1;
   localparam int NUM_THREADS = 4;
   localparam int NUM_WARPS   = 4;
   localparam int UUID_WIDTH  = 8;
   localparam int DATA_W      = 16;
   localparam int NW_WIDTH    = 2;
   localparam int PID_WIDTH   = 2;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [NUM_LANES-1:0] mask;
      logic                 done;
   } beat_t;

   typedef struct packed {
      logic [NW_WIDTH-1:0]   wid;
      logic [PID_WIDTH-1:0]  pid;
      logic [NUM_LANES-1:0]  tmask;
      logic [DATA_W-1:0]     data;
      logic [UUID_WIDTH-1:0] uuid;
   } wr_t;

   typedef struct packed {
      logic [NW_WIDTH-1:0]    wid;
      logic [NUM_THREADS-1:0] tmask;
      logic [UUID_WIDTH-1:0]  uuid;
   } rsp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   raster_fetch_sched_if #(
      .NUM_LANES(NUM_LANES), .NUM_THREADS(NUM_THREADS), .NUM_WARPS(NUM_WARPS),
      .UUID_WIDTH(UUID_WIDTH), .DATA_W(DATA_W)
   ) bus ();

   raster_fetch_sched #(
      .NUM_LANES(NUM_LANES), .NUM_THREADS(NUM_THREADS), .NUM_WARPS(NUM_WARPS),
      .UUID_WIDTH(UUID_WIDTH), .DATA_W(DATA_W)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   beat_t stamp_q[$];
   wr_t   exp_wr[$];
   rsp_t  exp_rsp[$];
   int    checks = 0;
   int    errors = 0;
   logic  sr_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input logic [DATA_W-1:0] d, input logic m, input logic dn);
      beat_t b;
      b.data = d;
      b.mask = m;
      b.done = dn;
      stamp_q.push_back(b);
   endtask

   task automatic push_wr(input logic [1:0] wid, input logic [1:0] pid,
                          input logic [DATA_W-1:0] d, input logic [7:0] uuid);
      wr_t w;
      w.wid   = wid;
      w.pid   = pid;
      w.tmask = 1'b1;
      w.data  = d;
      w.uuid  = uuid;
      exp_wr.push_back(w);
   endtask

   task automatic push_rsp(input logic [1:0] wid, input logic [3:0] tm, input logic [7:0] uuid);
      rsp_t r;
      r.wid   = wid;
      r.tmask = tm;
      r.uuid  = uuid;
      exp_rsp.push_back(r);
   endtask

   task automatic send_req(input logic [1:0] wid, input logic [3:0] tm, input logic [7:0] uuid);
      int n;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_wid   = wid;
      bus.req_tmask = tm;
      bus.req_uuid  = uuid;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.req_ready) begin
         errors++;
         $display("FAIL req_accept: wid %0d req_ready got 0 expected 1", wid);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_rsp.size() != 0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: outstanding rsp %0d wr %0d expected 0 0",
                  name, exp_rsp.size(), exp_wr.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // stamp source: present the queue head; pop when the DUT will take it at the next edge
   initial begin
      bus.stamp_valid = 1'b0;
      bus.stamp_data  = '0;
      bus.stamp_mask  = '0;
      bus.stamp_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (stamp_q.size() > 0) begin
            bus.stamp_valid = 1'b1;
            bus.stamp_data  = stamp_q[0].data;
            bus.stamp_mask  = stamp_q[0].mask;
            bus.stamp_done  = stamp_q[0].done;
            if (bus.stamp_ready) void'(stamp_q.pop_front());
         end else begin
            bus.stamp_valid = 1'b0;
            bus.stamp_done  = 1'b0;
         end
      end
   end

   // monitor: scoreboard for writes and responses
   initial begin
      wr_t  aw;
      wr_t  ew;
      rsp_t ar;
      rsp_t er;
      sr_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.stamp_ready) sr_seen = 1'b1;
         if (bus.write_enable) begin
            aw.wid   = bus.write_wid;
            aw.pid   = bus.write_pid;
            aw.tmask = bus.write_tmask;
            aw.data  = bus.write_data;
            aw.uuid  = bus.write_uuid;
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got wid %0d pid %0d data 0x%0h expected no write",
                        aw.wid, aw.pid, aw.data);
            end else begin
               ew = exp_wr.pop_front();
               check("write", 64'(aw), 64'(ew));
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            ar.wid   = bus.rsp_wid;
            ar.tmask = bus.rsp_tmask;
            ar.uuid  = bus.rsp_uuid;
            if (exp_rsp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got wid %0d tmask 0x%0h expected no response",
                        ar.wid, ar.tmask);
            end else begin
               er = exp_rsp.pop_front();
               check("response", 64'(ar), 64'(er));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] d;
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_wid   = '0;
      bus.req_tmask = '0;
      bus.req_uuid  = '0;
      bus.rsp_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stamp_ready", bus.stamp_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_write_enable", bus.write_enable, 0);
      check("rst_req_ready", bus.req_ready, 1);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // single fetch: warp 2, tmask 1011 -> pids 0,1,3
      push_beat(16'h0100, 1'b1, 1'b0);
      push_beat(16'h0101, 1'b1, 1'b0);
      push_beat(16'h0102, 1'b1, 1'b0);
      push_wr(2'd2, 2'd0, 16'h0100, 8'h21);
      push_wr(2'd2, 2'd1, 16'h0101, 8'h21);
      push_wr(2'd2, 2'd3, 16'h0102, 8'h21);
      push_rsp(2'd2, 4'b1011, 8'h21);
      send_req(2'd2, 4'b1011, 8'h21);
      wait_drain("single");

      // round-robin: 0,1,3 then re-request 0 while 3 still pending -> 0,1,3,0
      do_reset();
      d = 16'h0110;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] w;
         logic [7:0] u;
         case (k)
            0: begin w = 2'd0; u = 8'h30; end
            1: begin w = 2'd1; u = 8'h31; end
            2: begin w = 2'd3; u = 8'h33; end
            default: begin w = 2'd0; u = 8'h40; end
         endcase
         for (int p = 0; p < 4; p++) begin
            push_beat(d, 1'b1, 1'b0);
            push_wr(w, 2'(p), d, u);
            d = d + 16'd1;
         end
         push_rsp(w, 4'hF, u);
      end
      send_req(2'd0, 4'hF, 8'h30);
      send_req(2'd1, 4'hF, 8'h31);
      send_req(2'd3, 4'hF, 8'h33);
      n = 0;
      while (exp_rsp.size() > 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rr_first_rsp_seen", (exp_rsp.size() == 3), 1);
      send_req(2'd0, 4'hF, 8'h40);
      wait_drain("round_robin");

      // early done: second beat carries done with empty mask
      push_beat(16'h0200, 1'b1, 1'b0);
      push_beat(16'h0201, 1'b0, 1'b1);
      push_beat(16'h0202, 1'b1, 1'b0);
      push_wr(2'd1, 2'd0, 16'h0200, 8'h51);
      push_rsp(2'd1, 4'b0001, 8'h51);
      send_req(2'd1, 4'hF, 8'h51);
      wait_drain("early_done");
      repeat (2) @(negedge clk);
      check("early_done_stamps_left", stamp_q.size(), 1);
      @(posedge clk); #1;
      stamp_q.delete();

      // response backpressure
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      push_beat(16'h0300, 1'b1, 1'b0);
      push_wr(2'd0, 2'd2, 16'h0300, 8'h60);
      push_rsp(2'd0, 4'b0100, 8'h60);
      send_req(2'd0, 4'b0100, 8'h60);
      n = 0;
      while (!bus.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_rsp_valid_rise", bus.rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", bus.rsp_valid, 1);
         check("bp_rsp_payload", {bus.rsp_wid, bus.rsp_tmask, bus.rsp_uuid}, {2'd0, 4'b0100, 8'h60});
         check("bp_stamp_ready", bus.stamp_ready, 0);
         check("bp_req_ready_same_wid", bus.req_ready, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      wait_drain("backpressure");

      // zero thread mask
      @(posedge clk); #1;
      sr_seen = 1'b0;
      push_rsp(2'd3, 4'b0000, 8'h70);
      send_req(2'd3, 4'b0000, 8'h70);
      wait_drain("zero_tmask");
      check("zero_tmask_stamp_ready_seen", sr_seen, 0);

      // reset in the middle of a 4-beat fetch
      for (int p = 0; p < 4; p++) push_beat(16'h0400 + 16'(p), 1'b1, 1'b0);
      push_wr(2'd2, 2'd0, 16'h0400, 8'h80);
      send_req(2'd2, 4'hF, 8'h80);
      n = 0;
      while (!bus.write_enable && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_reset_first_write", bus.write_enable, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      stamp_q.delete();
      @(negedge clk);
      check("mid_reset_stamp_ready", bus.stamp_ready, 0);
      check("mid_reset_rsp_valid", bus.rsp_valid, 0);
      check("mid_reset_write_enable", bus.write_enable, 0);
      check("mid_reset_req_ready", bus.req_ready, 1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_reset_no_rsp", bus.rsp_valid, 0);
      push_beat(16'h0500, 1'b1, 1'b0);
      push_wr(2'd2, 2'd1, 16'h0500, 8'h81);
      push_rsp(2'd2, 4'b0010, 8'h81);
      send_req(2'd2, 4'b0010, 8'h81);
      wait_drain("after_reset");

      repeat (4) @(negedge clk);
      check("final_exp_wr_empty", exp_wr.size(), 0);
      check("final_exp_rsp_empty", exp_rsp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
